pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter WIDTH, default 32, PC/address width; legal range 29..64.
REQ-002 Parameter RESET_PC, default 32'h0000_3000, PC value loaded by reset.
REQ-003 Parameter EXC_PC, default 32'h0000_4180, exception entry address.
REQ-004 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port stall  in  1  hold fetch PC this cycle.
REQ-007 Port pc_d  in  WIDTH  PC of the instruction in the D stage.
REQ-008 Port imm26  in  26  instruction index field; [15:0] is the branch offset.
REQ-009 Port rs_val  in  WIDTH  forwarded rs value, used as the jr target.
REQ-010 Port zero, more, less  in  1 each  comparator flags for the D-stage branch.
REQ-011 Port br_type  in  3  0 none, 1 beq, 2 bne, 3 bgtz, 4 blez, 5 bgez, 6 bltz, 7 reserved (treated as none).
REQ-012 Port is_j  in  1  j/jal in D; is_jr  in  1  jr/jalr in D.
REQ-013 Port exc_req  in  1  exception entry; eret  in  1  return; epc  in  WIDTH  return address.
REQ-014 Port pc  out  WIDTH  registered fetch PC; pc_plus4  out  WIDTH  pc+4.
REQ-015 Port taken  out  1  combinational; D-stage redirect resolved this cycle.
REQ-016 Port pending  out  1  registered; latched redirect awaiting stall release.
REQ-017 Port adel_if  out  1  combinational; high when pc[1:0] != 0.

Function
REQ-018 Branch condition: beq&zero, bne&!zero, bgtz&more, blez&!more, bgez&!less, bltz&less.
REQ-019 Branch target = pc_d + 4 + (sign-extended imm26[15:0] << 2), modulo 2^WIDTH.
REQ-020 Jump target = {(pc_d+4)[WIDTH-1:28], imm26, 2'b00}; jr target = rs_val, unmodified.
REQ-021 Redirect priority: jr > j > taken branch; taken = is_jr | is_j | branch condition true.
REQ-022 State: pending register (1 bit) plus pend_tgt register (WIDTH).
REQ-023 Next-PC priority each edge: reset > exc_req > eret > stall > pending > taken > sequential.
REQ-024 exc_req: pc <= EXC_PC and pending <= 0, irrespective of stall.
REQ-025 eret (exc_req low): pc <= epc and pending <= 0, irrespective of stall.
REQ-026 stall high with taken high: pc holds; pending <= 1; pend_tgt <= the resolved target (a later taken overwrites it).
REQ-027 stall high with taken low: pc and pending both hold.
REQ-028 stall low with pending high: pc <= pend_tgt and pending <= 0; taken is ignored this cycle.
REQ-029 stall low, pending low, taken high: pc <= resolved target.
REQ-030 Otherwise: pc <= pc + 4, wrapping modulo 2^WIDTH (all-ones-minus-3 wraps to 0).
REQ-031 pc_plus4 = pc + 4, same wrap; zero-cycle combinational path from pc.
REQ-032 The block does not trap misalignment; a misaligned jr/epc target is loaded and adel_if flags it.
REQ-033 Latency: a redirect resolved in cycle N appears on pc at edge N+1, or at the first unstalled edge.

Reset
REQ-034 On reset edge: pc <= RESET_PC, pending <= 0, pend_tgt <= 0; this overrides all other inputs.
REQ-035 Reset asserted mid-stall with pending high discards the latched target.

Verification
REQ-036 Reset then 3 free cycles -> pc 0x3000, 0x3004, 0x3008, 0x300C; pending=0.
REQ-037 pc_d=0x3010, br_type=1, zero=1, imm16=0xFFFC, stall=0 -> taken=1, next pc=0x3004.
REQ-038 is_jr=1, rs_val=0x3400, stall=1 for 2 cycles then 0 -> pc held, pending=1, then pc=0x3400, pending=0.
REQ-039 pending=1 and exc_req=1 in the same cycle -> pc=0x4180, pending=0; next cycle eret=1, epc=0x3020 -> pc=0x3020.
REQ-040 WIDTH=32, pc=0xFFFF_FFFC, no redirect -> pc=0x0000_0000; is_j with pc_d=0x9000_0000, imm26=0x100 -> pc=0x9000_0400.
REQ-041 is_jr=1, rs_val=0x3002 -> pc=0x3002, adel_if=1.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch-PC generator: sequential increment, D-stage branch/jump/jr redirect,
// exception entry/return, and a one-deep latch for redirects resolved under stall.
module pc_gen #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_PC   = WIDTH'(32'h0000_4180)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [WIDTH-1:0] pc_d,
    input  logic [25:0]      imm26,
    input  logic [WIDTH-1:0] rs_val,
    input  logic             zero,
    input  logic             more,
    input  logic             less,
    input  logic [2:0]       br_type,
    input  logic             is_j,
    input  logic             is_jr,
    input  logic             exc_req,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             taken,
    output logic             pending,
    output logic             adel_if
);

    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic             pending_q, pending_d;

    logic             br_cond;
    logic [WIDTH-1:0] seq_d;
    logic [WIDTH-1:0] br_off;
    logic [WIDTH-1:0] br_tgt;
    logic [WIDTH-1:0] j_tgt;
    logic [WIDTH-1:0] redir_tgt;

    always_comb begin
        br_cond = 1'b0;
        case (br_type)
            3'd1:    br_cond = zero;
            3'd2:    br_cond = ~zero;
            3'd3:    br_cond = more;
            3'd4:    br_cond = ~more;
            3'd5:    br_cond = ~less;
            3'd6:    br_cond = less;
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        seq_d     = pc_d + WIDTH'(32'd4);
        br_off    = {{(WIDTH-18){imm26[15]}}, imm26[15:0], 2'b00};
        br_tgt    = seq_d + br_off;
        j_tgt     = {seq_d[WIDTH-1:28], imm26, 2'b00};
        taken     = is_jr | is_j | br_cond;
        redir_tgt = is_jr ? rs_val : (is_j ? j_tgt : br_tgt);
    end

    // Exception entry/return bypass stall and drop any latched redirect.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pending_d  = pending_q;
        pend_tgt_d = pend_tgt_q;
        if (exc_req) begin
            fetch_pc_d = EXC_PC;
            pending_d  = 1'b0;
        end else if (eret) begin
            fetch_pc_d = epc;
            pending_d  = 1'b0;
        end else if (stall) begin
            if (taken) begin
                pending_d  = 1'b1;
                pend_tgt_d = redir_tgt;
            end
        end else if (pending_q) begin
            fetch_pc_d = pend_tgt_q;
            pending_d  = 1'b0;
        end else if (taken) begin
            fetch_pc_d = redir_tgt;
        end else begin
            fetch_pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            pending_q  <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pending_q  <= pending_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign pc       = fetch_pc_q;
    assign pc_plus4 = fetch_pc_q + WIDTH'(32'd4);
    assign pending  = pending_q;
    assign adel_if  = (fetch_pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen at the default 32-bit width.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] pc_d = '0;
    logic [25:0] imm26 = '0;
    logic [31:0] rs_val = '0;
    logic        zero = 1'b0;
    logic        more = 1'b0;
    logic        less = 1'b0;
    logic [2:0]  br_type = '0;
    logic        is_j = 1'b0;
    logic        is_jr = 1'b0;
    logic        exc_req = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc = '0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        taken;
    logic        pending;
    logic        adel_if;

    int passed = 0;
    int total  = 0;

    pc_gen #(.WIDTH(32), .RESET_PC(32'h0000_3000), .EXC_PC(32'h0000_4180)) dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_d(pc_d), .imm26(imm26),
        .rs_val(rs_val), .zero(zero), .more(more), .less(less), .br_type(br_type),
        .is_j(is_j), .is_jr(is_jr), .exc_req(exc_req), .eret(eret), .epc(epc),
        .pc(pc), .pc_plus4(pc_plus4), .taken(taken), .pending(pending), .adel_if(adel_if)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        reset = 0; stall = 0; pc_d = '0; imm26 = '0; rs_val = '0;
        zero = 0; more = 0; less = 0; br_type = '0; is_j = 0; is_jr = 0;
        exc_req = 0; eret = 0; epc = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_seq [4];
        exp_seq = '{32'h3000, 32'h3004, 32'h3008, 32'h300C};
        // Reset must win over a simultaneous exception request.
        clear_inputs();
        reset = 1; exc_req = 1;
        step();
        reset = 0; exc_req = 0;
        total++; if (pending !== 1'b0) $display("FAIL reset_pending got=%0b exp=0", pending); else passed++;
        total++; if (pc_plus4 !== 32'h3004) $display("FAIL reset_pc_plus4 got=%h exp=00003004", pc_plus4); else passed++;
        total++; if (adel_if !== 1'b0) $display("FAIL reset_adel got=%0b exp=0", adel_if); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (pc !== exp_seq[i]) $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc, exp_seq[i]);
            else passed++;
            if (i < 3) step();
        end
        total++; if (pending !== 1'b0) $display("FAIL seq_pending got=%0b exp=0", pending); else passed++;
    endtask

    task automatic test_branch();
        // br_type, zero, more, less, expected taken
        logic [6:0] vec [10];
        vec = '{
            {3'd1, 1'b1, 1'b0, 1'b0, 1'b1},
            {3'd1, 1'b0, 1'b0, 1'b0, 1'b0},
            {3'd2, 1'b1, 1'b0, 1'b0, 1'b0},
            {3'd2, 1'b0, 1'b0, 1'b0, 1'b1},
            {3'd3, 1'b0, 1'b1, 1'b0, 1'b1},
            {3'd4, 1'b0, 1'b1, 1'b0, 1'b0},
            {3'd5, 1'b0, 1'b0, 1'b0, 1'b1},
            {3'd6, 1'b0, 1'b0, 1'b1, 1'b1},
            {3'd7, 1'b1, 1'b1, 1'b1, 1'b0},
            {3'd0, 1'b1, 1'b1, 1'b1, 1'b0}
        };
        do_reset();
        for (int i = 0; i < 10; i++) begin
            {br_type, zero, more, less} = vec[i][6:1];
            #1;
            total++;
            if (taken !== vec[i][0]) $display("FAIL br_cond[%0d] got=%0b exp=%0b", i, taken, vec[i][0]);
            else passed++;
        end
        pc_d = 32'h3010; br_type = 3'd1; zero = 1; more = 0; less = 0; imm26 = 26'h000FFFC;
        #1;
        total++; if (taken !== 1'b1) $display("FAIL beq_taken got=%0b exp=1", taken); else passed++;
        step();
        total++; if (pc !== 32'h3004) $display("FAIL beq_target got=%h exp=00003004", pc); else passed++;
        // Not-taken bne falls through to sequential.
        br_type = 3'd2;
        step();
        total++; if (pc !== 32'h3008) $display("FAIL bne_fallthrough got=%h exp=00003008", pc); else passed++;
        // Forward branch: 0x3100 + 4 + (0x10 << 2) = 0x3144.
        pc_d = 32'h3100; br_type = 3'd6; less = 1; imm26 = 26'h0000010;
        step();
        total++; if (pc !== 32'h3144) $display("FAIL bltz_target got=%h exp=00003144", pc); else passed++;
        clear_inputs();
    endtask

    task automatic test_stall_pending();
        do_reset();
        is_jr = 1; rs_val = 32'h3400; stall = 1;
        step();
        total++; if (pc !== 32'h3000) $display("FAIL stall1_pc got=%h exp=00003000", pc); else passed++;
        total++; if (pending !== 1'b1) $display("FAIL stall1_pending got=%0b exp=1", pending); else passed++;
        step();
        total++; if (pc !== 32'h3000) $display("FAIL stall2_pc got=%h exp=00003000", pc); else passed++;
        total++; if (pending !== 1'b1) $display("FAIL stall2_pending got=%0b exp=1", pending); else passed++;
        // On release, a new redirect must be ignored in favour of the latched one.
        stall = 0; is_jr = 0; is_j = 1; pc_d = 32'h0000_5000; imm26 = 26'h0000200;
        step();
        total++; if (pc !== 32'h3400) $display("FAIL release_pc got=%h exp=00003400", pc); else passed++;
        total++; if (pending !== 1'b0) $display("FAIL release_pending got=%0b exp=0", pending); else passed++;
        // Second stalled redirect overwrites the first latched target.
        is_j = 0; is_jr = 1; rs_val = 32'h3500; stall = 1;
        step();
        rs_val = 32'h3600;
        step();
        is_jr = 0; stall = 1;
        step();
        total++; if (pc !== 32'h3400) $display("FAIL hold_nontaken_pc got=%h exp=00003400", pc); else passed++;
        stall = 0;
        step();
        total++; if (pc !== 32'h3600) $display("FAIL overwrite_pc got=%h exp=00003600", pc); else passed++;
        clear_inputs();
    endtask

    task automatic test_exception();
        do_reset();
        stall = 1; is_jr = 1; rs_val = 32'h3400;
        step();
        is_jr = 0; exc_req = 1;
        step();
        total++; if (pc !== 32'h4180) $display("FAIL exc_pc got=%h exp=00004180", pc); else passed++;
        total++; if (pending !== 1'b0) $display("FAIL exc_pending got=%0b exp=0", pending); else passed++;
        exc_req = 0; eret = 1; epc = 32'h3020;
        step();
        total++; if (pc !== 32'h3020) $display("FAIL eret_pc got=%h exp=00003020", pc); else passed++;
        eret = 0; stall = 0;
        step();
        total++; if (pc !== 32'h3024) $display("FAIL post_eret_pc got=%h exp=00003024", pc); else passed++;
        // Exception takes priority over a simultaneous eret.
        exc_req = 1; eret = 1; epc = 32'h7000;
        step();
        total++; if (pc !== 32'h4180) $display("FAIL exc_over_eret got=%h exp=00004180", pc); else passed++;
        clear_inputs();
    endtask

    task automatic test_wrap_jump();
        do_reset();
        eret = 1; epc = 32'hFFFF_FFFC;
        step();
        eret = 0;
        total++; if (pc_plus4 !== 32'h0) $display("FAIL wrap_pc_plus4 got=%h exp=00000000", pc_plus4); else passed++;
        step();
        total++; if (pc !== 32'h0) $display("FAIL wrap_pc got=%h exp=00000000", pc); else passed++;
        is_j = 1; pc_d = 32'h9000_0000; imm26 = 26'h0000100;
        step();
        total++; if (pc !== 32'h9000_0400) $display("FAIL j_target got=%h exp=90000400", pc); else passed++;
        clear_inputs();
    endtask

    task automatic test_priority();
        do_reset();
        is_jr = 1; rs_val = 32'h5000; is_j = 1; pc_d = 32'h0; imm26 = 26'h10;
        br_type = 3'd1; zero = 1;
        step();
        total++; if (pc !== 32'h5000) $display("FAIL jr_over_j got=%h exp=00005000", pc); else passed++;
        is_jr = 0;
        step();
        total++; if (pc !== 32'h0000_0040) $display("FAIL j_over_branch got=%h exp=00000040", pc); else passed++;
        clear_inputs();
    endtask

    task automatic test_misalign();
        do_reset();
        is_jr = 1; rs_val = 32'h3002;
        step();
        is_jr = 0;
        total++; if (pc !== 32'h3002) $display("FAIL misalign_pc got=%h exp=00003002", pc); else passed++;
        total++; if (adel_if !== 1'b1) $display("FAIL misalign_adel got=%0b exp=1", adel_if); else passed++;
        total++; if (pc_plus4 !== 32'h3006) $display("FAIL misalign_plus4 got=%h exp=00003006", pc_plus4); else passed++;
        clear_inputs();
    endtask

    task automatic test_reset_discards_pending();
        do_reset();
        stall = 1; is_jr = 1; rs_val = 32'h3800;
        step();
        is_jr = 0; reset = 1;
        step();
        reset = 0;
        total++; if (pc !== 32'h3000) $display("FAIL rst_pend_pc got=%h exp=00003000", pc); else passed++;
        total++; if (pending !== 1'b0) $display("FAIL rst_pend_pending got=%0b exp=0", pending); else passed++;
        stall = 0;
        step();
        total++; if (pc !== 32'h3004) $display("FAIL rst_pend_next got=%h exp=00003004", pc); else passed++;
        clear_inputs();
    endtask

    initial begin
        #2;
        test_reset();
        test_branch();
        test_stall_pending();
        test_exception();
        test_wrap_jump();
        test_priority();
        test_misalign();
        test_reset_discards_pending();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
